// File: rtl/sys_pkg.sv
// Shared types for the SRAM read arbiter: owner ids, FSM states
// and the per-beat tag carried alongside each outstanding read.
package sys_pkg;

    typedef enum logic [0:0] {
        OWN_W = 1'b0,
        OWN_I = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST_W = 2'd1,
        BURST_I = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
        logic   last;
    } tag_t;

    localparam int LEN_WIDTH = 8;

endpackage

// File: rtl/rd_tag_pipe.sv
// Tag delay line matching the SRAM read latency.
// Ports: clk, rst (sync, active-high), tag_in (tag of the beat issued
// this cycle), tag_out (tag whose data is on mem_rd_data now),
// any_valid (some beat is still in flight).
module rd_tag_pipe
    import sys_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic any_valid
);

    tag_t stage [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < RD_LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[RD_LATENCY-1];

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            any_valid = any_valid | stage[i].valid;
        end
    end

endmodule

// File: rtl/sram_rd_arbiter.sv
// Two-requester burst read arbiter in front of a single-port SRAM.
// Ports: clk, rst (sync, active-high); req/addr/len/gnt/rdy per
// requester (_w weight, _i input); mem_rd_en/addr/data to the SRAM;
// rd_data with vld_x/done_x back to the owner; busy.
// Build option: define ARB_FIXED_PRIO_EN for fixed W-over-I priority
// on ties; otherwise ties are resolved round-robin.
module sram_rd_arbiter
    import sys_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_BAND   = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_w,
    input  logic                           req_i,
    input  logic [ADDR_WIDTH-1:0]          addr_w,
    input  logic [ADDR_WIDTH-1:0]          addr_i,
    input  logic [LEN_WIDTH-1:0]           len_w,
    input  logic [LEN_WIDTH-1:0]           len_i,
    output logic                           gnt_w,
    output logic                           gnt_i,
    input  logic                           rdy_w,
    input  logic                           rdy_i,
    output logic                           mem_rd_en,
    output logic [ADDR_WIDTH-1:0]          mem_rd_addr,
    input  logic [MEM_BAND*DATA_WIDTH-1:0] mem_rd_data,
    output logic [MEM_BAND*DATA_WIDTH-1:0] rd_data,
    output logic                           vld_w,
    output logic                           vld_i,
    output logic                           done_w,
    output logic                           done_i,
    output logic                           busy
);

    arb_state_t             state;
    arb_state_t             state_nxt;
    logic [ADDR_WIDTH-1:0]  cur_addr;
    logic [LEN_WIDTH-1:0]   beats_left;
    logic                   gnt_ok;
    logic                   pick_w;
    logic                   pick_i;
    logic                   issue_last;
    owner_t                 issue_own;
    tag_t                   tag_in;
    tag_t                   tag_out;
    logic                   tag_busy;
`ifndef ARB_FIXED_PRIO_EN
    owner_t                 last_owner;
`endif

    // Tie resolution between the two requesters.
    always_comb begin
        pick_w = req_w;
        pick_i = req_i;
        if (req_w && req_i) begin
`ifdef ARB_FIXED_PRIO_EN
            pick_w = 1'b1;
            pick_i = 1'b0;
`else
            pick_w = (last_owner == OWN_I);
            pick_i = (last_owner == OWN_W);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (gnt_w) begin
                    state_nxt = BURST_W;
                end else if (gnt_i) begin
                    state_nxt = BURST_I;
                end
            end
            BURST_W, BURST_I: begin
                if (mem_rd_en && issue_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // gnt_ok holds grants off for the first cycle after reset so that
    // every output reads zero in that cycle.
    always_comb begin
        gnt_w       = 1'b0;
        gnt_i       = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        issue_own   = OWN_W;
        unique case (state)
            IDLE: begin
                gnt_w = gnt_ok && !rst && pick_w;
                gnt_i = gnt_ok && !rst && pick_i;
            end
            BURST_W: begin
                mem_rd_en   = rdy_w;
                mem_rd_addr = cur_addr;
                issue_own   = OWN_W;
            end
            BURST_I: begin
                mem_rd_en   = rdy_i;
                mem_rd_addr = cur_addr;
                issue_own   = OWN_I;
            end
            default: ;
        endcase
    end

    assign issue_last = (beats_left == LEN_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr   <= '0;
            beats_left <= '0;
            gnt_ok     <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last_owner <= OWN_I;
`endif
        end else begin
            gnt_ok <= 1'b1;
            if (gnt_w) begin
                cur_addr   <= addr_w;
                beats_left <= len_w;
`ifndef ARB_FIXED_PRIO_EN
                last_owner <= OWN_W;
`endif
            end else if (gnt_i) begin
                cur_addr   <= addr_i;
                beats_left <= len_i;
`ifndef ARB_FIXED_PRIO_EN
                last_owner <= OWN_I;
`endif
            end else if (mem_rd_en) begin
                cur_addr   <= cur_addr + 1'b1;
                beats_left <= beats_left - 1'b1;
            end
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = mem_rd_en;
        tag_in.owner = issue_own;
        tag_in.last  = issue_last;
    end

    rd_tag_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .tag_in    (tag_in),
        .tag_out   (tag_out),
        .any_valid (tag_busy)
    );

    // Return stage: the tag leaving the pipe names the owner of the
    // data currently on mem_rd_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
            vld_w   <= 1'b0;
            vld_i   <= 1'b0;
            done_w  <= 1'b0;
            done_i  <= 1'b0;
        end else begin
            if (tag_out.valid) begin
                rd_data <= mem_rd_data;
            end
            vld_w  <= tag_out.valid && (tag_out.owner == OWN_W);
            vld_i  <= tag_out.valid && (tag_out.owner == OWN_I);
            done_w <= tag_out.valid && (tag_out.owner == OWN_W)
                      && tag_out.last;
            done_i <= tag_out.valid && (tag_out.owner == OWN_I)
                      && tag_out.last;
        end
    end

    assign busy = (state != IDLE) || tag_busy || vld_w || vld_i;

endmodule

// File: tb/tb_sram_rd_arbiter.sv
// Self-checking bench for sram_rd_arbiter with an SRAM latency model
// and an in-order scoreboard of returned beats.
module tb_sram_rd_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MB = 16;
    localparam int RL = 2;
    localparam int BW = MB * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_w, req_i;
    logic [AW-1:0] addr_w, addr_i;
    logic [7:0]    len_w, len_i;
    logic          gnt_w, gnt_i;
    logic          rdy_w, rdy_i;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [BW-1:0] mem_rd_data;
    logic [BW-1:0] rd_data;
    logic          vld_w, vld_i, done_w, done_i, busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          own;
        logic [BW-1:0] data;
        logic          last;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    sram_rd_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_BAND   (MB),
        .RD_LATENCY (RL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_w       (req_w),
        .req_i       (req_i),
        .addr_w      (addr_w),
        .addr_i      (addr_i),
        .len_w       (len_w),
        .len_i       (len_i),
        .gnt_w       (gnt_w),
        .gnt_i       (gnt_i),
        .rdy_w       (rdy_w),
        .rdy_i       (rdy_i),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .rd_data     (rd_data),
        .vld_w       (vld_w),
        .vld_i       (vld_i),
        .done_w      (done_w),
        .done_i      (done_i),
        .busy        (busy)
    );

    function automatic logic [BW-1:0] mem_word(input logic [AW-1:0] a);
        logic [BW-1:0] w;
        for (int k = 0; k < MB; k++) begin
            w[k*DW +: DW] = a ^ 8'(k * 37 + 1);
        end
        return w;
    endfunction

    // SRAM model: data for the address issued RL cycles earlier.
    logic [AW-1:0] ap [RL];
    always @(posedge clk) begin
        ap[0] <= mem_rd_addr;
        for (int i = 1; i < RL; i++) ap[i] <= ap[i-1];
    end
    assign mem_rd_data = mem_word(ap[RL-1]);

    task automatic push_burst(input logic own, input logic [AW-1:0] a,
                              input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.own  = own;
            e.data = mem_word(a + 8'(k));
            e.last = (k == n - 1);
            sb.push_back(e);
        end
    endtask

    // Scoreboard and exclusivity monitor.
    always @(negedge clk) begin
        exp_t e;
        if (gnt_w && gnt_i) begin
            checks++; errors++;
            $display("FAIL gnt_excl gnt_w=1 gnt_i=1 required one-hot");
        end
        if (vld_w && vld_i) begin
            checks++; errors++;
            $display("FAIL vld_excl vld_w=1 vld_i=1 required one-hot");
        end
        if ((done_w && !vld_w) || (done_i && !vld_i)) begin
            checks++; errors++;
            $display("FAIL done_alone done_w=%0d done_i=%0d vld 0",
                     done_w, done_i);
        end
        if (vld_w || vld_i) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL beat_unexp vld_w=%0d vld_i=%0d none due",
                         vld_w, vld_i);
            end else begin
                e = sb.pop_front();
                if (vld_i !== e.own || rd_data !== e.data ||
                    (vld_i ? done_i : done_w) !== e.last) begin
                    errors++;
                    $display("FAIL beat got own=%0d last=%0d data=%h req own=%0d last=%0d data=%h",
                             vld_i, vld_i ? done_i : done_w, rd_data,
                             e.own, e.last, e.data);
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_timeout busy=%0d pending=%0d req 0/0",
                     busy, sb.size());
        end
    endtask

    task automatic test_reset();
        req_w = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt_w, gnt_i, vld_w, vld_i, done_w, done_i, mem_rd_en, busy}
            !== 8'h00 || mem_rd_addr !== '0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset_outs gnt=%b%b vld=%b%b busy=%b en=%b req 0",
                     gnt_w, gnt_i, vld_w, vld_i, busy, mem_rd_en);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (gnt_w !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_next gnt_w=%0d busy=%0d req 0 0",
                     gnt_w, busy);
        end
        @(posedge clk); #1;
        req_w = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        req_w = 1; addr_w = 8'h10; len_w = 8'd3; rdy_w = 1;
        @(negedge clk);
        checks++;
        if (gnt_w !== 1'b1) begin
            errors++;
            $display("FAIL single_gnt gnt_w=%0d req 1", gnt_w);
        end
        push_burst(1'b0, 8'h10, 3);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            req_w = 0;
            @(negedge clk);
            checks++;
            if (c <= 3) begin
                if (mem_rd_en !== 1'b1 || mem_rd_addr !== 8'(8'h0F + c)) begin
                    errors++;
                    $display("FAIL single_addr c=%0d en=%0d addr=%h req %h",
                             c, mem_rd_en, mem_rd_addr, 8'(8'h0F + c));
                end
            end else if (vld_w !== 1'b1 || done_w !== (c == 6)) begin
                errors++;
                $display("FAIL single_vld c=%0d vld_w=%0d done_w=%0d req 1 %0d",
                         c, vld_w, done_w, c == 6);
            end
        end
        wait_idle(20);
    endtask

    task automatic test_tie();
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        req_w = 1; addr_w = 8'h20; len_w = 8'd2; rdy_w = 1;
        req_i = 1; addr_i = 8'h40; len_i = 8'd2; rdy_i = 1;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (c == 1) req_w = 0;
            if (c == 4) req_i = 0;
            @(negedge clk);
            checks++;
            if (c == 0) begin
                push_burst(1'b0, 8'h20, 2);
                if (gnt_w !== 1'b1 || gnt_i !== 1'b0) begin
                    errors++;
                    $display("FAIL tie_first gnt_w=%0d gnt_i=%0d req 1 0",
                             gnt_w, gnt_i);
                end
            end else if (c == 3) begin
                push_burst(1'b1, 8'h40, 2);
                if (gnt_i !== 1'b1 || mem_rd_en !== 1'b0) begin
                    errors++;
                    $display("FAIL tie_second gnt_i=%0d en=%0d req 1 0",
                             gnt_i, mem_rd_en);
                end
            end else begin
                logic [AW-1:0] ea;
                ea = (c < 3) ? 8'(8'h1F + c) : 8'(8'h3C + c);
                if (gnt_i !== 1'b0 || mem_rd_en !== 1'b1 ||
                    mem_rd_addr !== ea) begin
                    errors++;
                    $display("FAIL tie_issue c=%0d gnt_i=%0d en=%0d addr=%h req 0 1 %h",
                             c, gnt_i, mem_rd_en, mem_rd_addr, ea);
                end
            end
        end
        wait_idle(20);
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [4];
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF;
        exp_a[2] = 8'h00; exp_a[3] = 8'h01;
        @(posedge clk); #1;
        req_i = 1; addr_i = 8'hFE; len_i = 8'd4; rdy_i = 1;
        push_burst(1'b1, 8'hFE, 4);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            req_i = 0;
            @(negedge clk);
            checks++;
            if (mem_rd_en !== 1'b1 || mem_rd_addr !== exp_a[c-1]) begin
                errors++;
                $display("FAIL wrap_addr c=%0d en=%0d addr=%h req %h",
                         c, mem_rd_en, mem_rd_addr, exp_a[c-1]);
            end
        end
        wait_idle(20);
    endtask

    task automatic test_stall();
        int pulses = 0;
        int dones = 0;
        @(posedge clk); #1;
        req_w = 1; addr_w = 8'h30; len_w = 8'd5; rdy_w = 1;
        push_burst(1'b0, 8'h30, 5);
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                req_w = 0;
                rdy_w = !(c >= 3 && c <= 5);
            end
            @(negedge clk);
            if (done_w) dones++;
            if (mem_rd_en) begin
                checks++;
                if (mem_rd_addr !== 8'(8'h30 + pulses) || !rdy_w) begin
                    errors++;
                    $display("FAIL stall_addr c=%0d addr=%h rdy=%0d req %h",
                             c, mem_rd_addr, rdy_w, 8'(8'h30 + pulses));
                end
                pulses++;
            end
        end
        rdy_w = 1;
        checks++;
        if (pulses != 5 || dones != 1) begin
            errors++;
            $display("FAIL stall_count pulses=%0d dones=%0d req 5 1",
                     pulses, dones);
        end
        wait_idle(20);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        req_w = 1; addr_w = 8'h50; len_w = 8'd6; rdy_w = 1;
        @(negedge clk);
        checks++;
        if (gnt_w !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_gnt gnt_w=%0d req 1", gnt_w);
        end
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 1) req_w = 0;
            if (c == 3) rst = 1;
            if (c == 4) rst = 0;
            @(negedge clk);
            if (c == 4) begin
                checks++;
                if (busy !== 1'b0 || mem_rd_en !== 1'b0 ||
                    rd_data !== '0 || mem_rd_addr !== '0) begin
                    errors++;
                    $display("FAIL rstmid_idle busy=%0d en=%0d addr=%h req 0 0 0",
                             busy, mem_rd_en, mem_rd_addr);
                end
            end
            if (c >= 4) begin
                checks++;
                if (vld_w !== 1'b0 || done_w !== 1'b0) begin
                    errors++;
                    $display("FAIL rstmid_flush c=%0d vld_w=%0d done_w=%0d req 0 0",
                             c, vld_w, done_w);
                end
            end
        end
    endtask

    task automatic test_arbitration();
        int   n = 0;
        logic exp_own = 1'b0;
        @(posedge clk); #1;
        req_w = 1; addr_w = 8'h60; len_w = 8'd1; rdy_w = 1;
        req_i = 1; addr_i = 8'h70; len_i = 8'd1; rdy_i = 1;
        for (int c = 0; c < 40 && n < 8; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            if (gnt_w || gnt_i) begin
                checks++;
                if (gnt_i !== exp_own) begin
                    errors++;
                    $display("FAIL arb_owner n=%0d gnt_w=%0d gnt_i=%0d req own %0d",
                             n, gnt_w, gnt_i, exp_own);
                end
                push_burst(exp_own, exp_own ? 8'h70 : 8'h60, 1);
                n++;
`ifndef ARB_FIXED_PRIO_EN
                exp_own = !exp_own;
`endif
            end
        end
        @(posedge clk); #1;
        req_w = 0; req_i = 0;
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL arb_count grants=%0d req 8", n);
        end
        wait_idle(20);
    endtask

    initial begin
        rst = 1; req_w = 0; req_i = 0;
        addr_w = '0; addr_i = '0; len_w = 8'd1; len_i = 8'd1;
        rdy_w = 1; rdy_i = 1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_tie();
        test_wrap();
        test_stall();
        test_reset_mid();
        test_arbitration();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_left pending=%0d req 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
